// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC register and fetch stage for CPU31. Drives the IMEM word
//            address and buffers fetched {instr, pc} pairs in a 2-entry queue
//            with a valid/ready handshake toward decode.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000,
  parameter int          AW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] im_addr,
  input  logic [31:0]   im_instr,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_pc4
);

  localparam logic [1:0] c_full = 2'd2;

  logic [31:0] r_pc;
  logic [31:0] r_slot_instr [2];
  logic [31:0] r_slot_pc    [2];
  logic [1:0]  r_count;
  logic        r_head;

  logic        w_deq;
  logic        w_enq;
  logic        w_tail;
  logic [1:0]  w_unused_redirect_lsb;

  assign w_unused_redirect_lsb = redirect_pc[1:0];

  assign im_addr   = r_pc[AW+1:2];
  assign out_valid = (r_count != 2'd0);
  assign out_instr = r_slot_instr[r_head];
  assign out_pc    = r_slot_pc[r_head];
  assign out_pc4   = out_pc + 32'd4;

  assign w_deq  = out_valid & out_ready;
  // A full queue can still accept when the head leaves in the same cycle.
  assign w_enq  = ~redirect_valid & ((r_count != c_full) | w_deq);
  assign w_tail = r_head ^ r_count[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc            <= PC_RESET;
      r_count         <= 2'd0;
      r_head          <= 1'b0;
      r_slot_instr[0] <= 32'd0;
      r_slot_instr[1] <= 32'd0;
      r_slot_pc[0]    <= 32'd0;
      r_slot_pc[1]    <= 32'd0;
    end else if (redirect_valid) begin
      // Any dequeue this cycle is still seen by decode; the entry is dropped.
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_count <= 2'd0;
    end else begin
      if (w_enq) begin
        r_slot_instr[w_tail] <= im_instr;
        r_slot_pc[w_tail]    <= r_pc;
        r_pc                 <= r_pc + 32'd4;
      end
      if (w_deq) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter and fetch stage feeding the instruction memory (IMEM) of the single-cycle/multicycle CPU31 datapath. Holds the PC and drives the 11-bit word address into IMEM's combinational read port. Captures the returned 32-bit instruction into a 2-entry buffer with a valid/ready handshake toward decode. Accepts PC redirects (branch/jump/exception) from downstream.

## Interface
- PC_RESET, 32'h0040_0000, PC value loaded on reset (MARS text base).
- AW, 11, IMEM word-address width (2048 words).
- clk  in  1  rising-edge clock for all state.
- rst  in  1  reset, asynchronous and active-high.
- im_addr  out  AW  word address to IMEM = pc[AW+1:2]; purely combinational from the pc register.
- im_instr  in  32  instruction from IMEM, valid in the same cycle as im_addr (asynchronous read).
- redirect_valid  in  1  load new PC this cycle.
- redirect_pc  in  32  target PC; bits [1:0] ignored (forced to 00).
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  32  PC of head instruction.
- out_pc4  out  32  out_pc + 4 (mod 2^32).

## Operation
- State: pc register (32 b); 2-entry queue of {instr, pc}; count in {0,1,2}; head pointer (1 b).
- deq = out_valid & out_ready.
- enq = !redirect_valid & (count < 2 | deq). On enq: push {im_instr, pc}; pc <= pc + 4.
- count_next = count + enq - deq; simultaneous enq and deq at count 2 or 1 keeps count; full throughput of one instruction per cycle with out_ready held high.
- No enq at count 2 without deq: pc holds, im_addr holds; no instruction lost or duplicated.
- Redirect (highest priority): queue flushed (count <= 0), pc <= {redirect_pc[31:2], 2'b00}; deq in the same cycle is still honoured by the consumer but the entry is discarded regardless; out_valid is 0 in the cycle after redirect.
- PC arithmetic is 32-bit wrap-around; im_addr is pc[AW+1:2], so the IMEM index wraps modulo 2^AW (e.g. pc 0x00401FFC -> 0x7FF, pc 0x00402000 -> 0x000). No range check.
- out_pc4 computed combinationally from out_pc.
- When count == 0, out_instr/out_pc show the (stale) head slot; consumers qualify with out_valid only.

## Timing
- Reset (async assert, any time): pc = PC_RESET, count = 0, head = 0, out_valid = 0, all queue slots cleared so out_instr = 0, out_pc = 0, out_pc4 = 4; im_addr = PC_RESET[AW+1:2] immediately.
- Reset deassertion is synchronous to clk in use; first enq at the first rising edge with rst low.
- Fetch latency: instruction at pc appears on out_instr with out_valid = 1 one cycle after im_addr presents it (registered capture).
- Redirect latency: redirect_valid sampled at edge N -> im_addr = target at N; target instruction at out_* with out_valid = 1 after edge N+1.
- out_valid, out_instr, out_pc depend only on registers (no combinational path from out_ready or redirect_valid).
- Reset mid-stream discards all buffered instructions; no partial state survives.

## Test plan
- Reset then out_ready = 1 for 6 cycles -> out_pc sequence 0x00400000, 0x00400004, 0x00400008, ... one per cycle, out_instr equals IMEM words 0,1,2,..., out_pc4 = out_pc + 4.
- Backpressure: out_ready = 0 from the first valid cycle for 5 cycles -> count reaches 2, pc holds at 0x00400008, im_addr holds 2; release -> words 0,1,2,3 delivered in order, none skipped or repeated.
- Redirect to 0x00400100 while buffer full -> cycle after: out_valid = 0, im_addr = 0x040; next cycle out_pc = 0x00400100, out_instr = IMEM[0x40].
- Misaligned redirect 0x00400103 -> pc = 0x00400100, im_addr = 0x040.
- Wrap: redirect to 0x00401FFC with out_ready = 1 -> im_addr 0x7FF then 0x000; out_pc 0x00401FFC then 0x00402000.
- Assert rst asynchronously mid-cycle during streaming -> out_valid falls immediately, im_addr = 0x000; after release stream restarts at 0x00400000.
